dice_roller_multi: RTL

Parametrised successor to the single-die roller top. It supports N dice of F faces each, with a debounced button, a free-running LFSR, a roll animation and an enforced minimum roll length. It drives one 7-segment digit per die and also outputs the sum of the dice. It sits directly behind the board button and ahead of the segment drivers, on the single system clock.

---
 rtl/dice_pkg.sv | 47 ++++
 rtl/dice_debounce.sv | 49 ++++
 rtl/dice_roller_multi.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the multi-die roller: FSM states, LFSR taps,
// active-low 7-segment digit patterns {g,f,e,d,c,b,a} and small helpers.
package dice_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROLL   = 2'd1,
    S_FINISH = 2'd2,
    S_SHOW   = 2'd3
  } state_e;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right-shifting)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/dice_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stable-count filter.
// rise is asserted in the cycle whose clock edge raises btn_db, so a consumer
// registering on rise changes state on the same edge as btn_db.
module dice_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_db,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  // Count consecutive cycles the synchronised level disagrees with btn_db
  always_comb begin
    accept = (sync_q[1] != db_q) && (cnt_q == CNT_LAST);
    db_d   = db_q;
    cnt_d  = '0;
    if (sync_q[1] != db_q) begin
      if (accept) db_d = sync_q[1];
      else        cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchroniser, filtered level and disagreement counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign btn_db = db_q;
  assign rise   = accept & sync_q[1];

endmodule

// File: rtl/dice_roller_multi.sv
// N-die roller: debounced button starts an animated roll driven by a
// free-running LFSR; a minimum number of animation steps is enforced before
// the final values latch. Drives one 7-segment digit per die plus the sum.
module dice_roller_multi
  import dice_pkg::*;
#(
  parameter int unsigned NUM_DICE        = 2,
  parameter int unsigned FACES           = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned ANIM_DIV        = 500,
  parameter int unsigned MIN_STEPS       = 8,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn,
  output logic [7*NUM_DICE-1:0] seg,
  output logic [4*NUM_DICE-1:0] die_val,
  output logic [5:0]            sum,
  output logic                  rolling,
  output logic                  roll_done,
  output logic [15:0]           roll_count
);

  localparam int unsigned TW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned SW = (MIN_STEPS > 0) ? $clog2(MIN_STEPS + 1) : 1;
  localparam logic [4*NUM_DICE-1:0] DIE_RST = {NUM_DICE{4'd1}};
  localparam logic [7*NUM_DICE-1:0] SEG_RST = {NUM_DICE{SEG_1}};

  state_e                state_q, state_d;
  logic                  btn_db, btn_rise;
  logic [15:0]           lfsr_q;
  logic [31:0]           lfsr_dbl;
  logic [TW-1:0]         tmr_q;
  logic [SW-1:0]         steps_q;
  logic                  step;
  logic [4*NUM_DICE-1:0] die_q, die_d;
  logic [5:0]            sum_q, sum_d;
  logic [7*NUM_DICE-1:0] seg_q, seg_d;
  logic                  roll_done_q;
  logic [15:0]           roll_count_q;

  dice_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .btn_db(btn_db),
    .rise  (btn_rise)
  );

  assign step     = (state_q == S_ROLL) && (tmr_q == TW'(ANIM_DIV - 1));
  assign lfsr_dbl = {lfsr_q, lfsr_q};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (btn_rise) state_d = S_ROLL;
      S_ROLL:   if (!btn_db && (steps_q >= SW'(MIN_STEPS))) state_d = S_FINISH;
      S_FINISH: state_d = S_SHOW;
      S_SHOW:   if (btn_rise) state_d = S_ROLL;
      default:  state_d = S_IDLE;
    endcase
  end

  // Animation timer and saturating step count; both held at zero outside
  // ROLL, which is equivalent to clearing them on entry to ROLL
  always_ff @(posedge clk) begin
    if (rst || (state_q != S_ROLL)) begin
      tmr_q   <= '0;
      steps_q <= '0;
    end else begin
      tmr_q <= step ? '0 : tmr_q + TW'(1);
      if (step && (steps_q < SW'(MIN_STEPS))) steps_q <= steps_q + SW'(1);
    end
  end

  // New die values from overlapping LFSR bytes on each step and at FINISH
  always_comb begin
    die_d = die_q;
    if (step || (state_q == S_FINISH)) begin
      for (int unsigned i = 0; i < NUM_DICE; i++) begin
        die_d[i*4 +: 4] = 4'((lfsr_dbl[i*4 +: 8] % 8'(FACES)) + 8'd1);
      end
    end
  end

  // Sum and segment patterns derived from the current die register
  always_comb begin
    sum_d = '0;
    seg_d = '0;
    for (int unsigned i = 0; i < NUM_DICE; i++) begin
      sum_d           = sum_d + 6'(die_q[i*4 +: 4]);
      seg_d[i*7 +: 7] = seg_decode(die_q[i*4 +: 4]);
    end
  end

  // LFSR, die values, display registers and roll bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q       <= LFSR_SEED;
      die_q        <= DIE_RST;
      sum_q        <= 6'(NUM_DICE);
      seg_q        <= SEG_RST;
      roll_done_q  <= 1'b0;
      roll_count_q <= '0;
    end else begin
      lfsr_q      <= lfsr_next(lfsr_q);
      die_q       <= die_d;
      sum_q       <= sum_d;
      seg_q       <= seg_d;
      roll_done_q <= (state_q == S_FINISH);
      if ((state_q == S_FINISH) && (roll_count_q != '1))
        roll_count_q <= roll_count_q + 16'd1;
    end
  end

  assign seg        = seg_q;
  assign die_val    = die_q;
  assign sum        = sum_q;
  assign rolling    = (state_q == S_ROLL) || (state_q == S_FINISH);
  assign roll_done  = roll_done_q;
  assign roll_count = roll_count_q;

endmodule
